// File: rtl/sm_display_pkg.sv
// Shared seven-segment definitions: segment bit positions, the 0-F glyph
// patterns (active-high, bit order {g,f,e,d,c,b,a}) and the digit-count limit.
package sm_display_pkg;

   // Maximum number of digits a display driver may scan; also sizes the data word.
   localparam int MAX_DIGITS = 8;

   // Segment bit positions within a 7-bit pattern.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SA = 7'(1) << SEG_A;
   localparam logic [6:0] SB = 7'(1) << SEG_B;
   localparam logic [6:0] SC = 7'(1) << SEG_C;
   localparam logic [6:0] SD = 7'(1) << SEG_D;
   localparam logic [6:0] SE = 7'(1) << SEG_E;
   localparam logic [6:0] SF = 7'(1) << SEG_F;
   localparam logic [6:0] SG = 7'(1) << SEG_G;

   // Hex glyphs, active-high.
   localparam logic [6:0] SEG_HEX_0 = SA | SB | SC | SD | SE | SF;       // 3F
   localparam logic [6:0] SEG_HEX_1 = SB | SC;                           // 06
   localparam logic [6:0] SEG_HEX_2 = SA | SB | SD | SE | SG;            // 5B
   localparam logic [6:0] SEG_HEX_3 = SA | SB | SC | SD | SG;            // 4F
   localparam logic [6:0] SEG_HEX_4 = SB | SC | SF | SG;                 // 66
   localparam logic [6:0] SEG_HEX_5 = SA | SC | SD | SF | SG;            // 6D
   localparam logic [6:0] SEG_HEX_6 = SA | SC | SD | SE | SF | SG;       // 7D
   localparam logic [6:0] SEG_HEX_7 = SA | SB | SC;                      // 07
   localparam logic [6:0] SEG_HEX_8 = SA | SB | SC | SD | SE | SF | SG;  // 7F
   localparam logic [6:0] SEG_HEX_9 = SA | SB | SC | SD | SF | SG;       // 6F
   localparam logic [6:0] SEG_HEX_A = SA | SB | SC | SE | SF | SG;       // 77
   localparam logic [6:0] SEG_HEX_B = SC | SD | SE | SF | SG;            // 7C
   localparam logic [6:0] SEG_HEX_C = SA | SD | SE | SF;                 // 39
   localparam logic [6:0] SEG_HEX_D = SB | SC | SD | SE | SG;            // 5E
   localparam logic [6:0] SEG_HEX_E = SA | SD | SE | SF | SG;            // 79
   localparam logic [6:0] SEG_HEX_F = SA | SE | SF | SG;                 // 71

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module sm_hex_to_seg
   import sm_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Look up the glyph for the nibble value.
   always_comb begin
      seg = SEG_HEX_0;
      case (nibble)
         4'h0:    seg = SEG_HEX_0;
         4'h1:    seg = SEG_HEX_1;
         4'h2:    seg = SEG_HEX_2;
         4'h3:    seg = SEG_HEX_3;
         4'h4:    seg = SEG_HEX_4;
         4'h5:    seg = SEG_HEX_5;
         4'h6:    seg = SEG_HEX_6;
         4'h7:    seg = SEG_HEX_7;
         4'h8:    seg = SEG_HEX_8;
         4'h9:    seg = SEG_HEX_9;
         4'hA:    seg = SEG_HEX_A;
         4'hB:    seg = SEG_HEX_B;
         4'hC:    seg = SEG_HEX_C;
         4'hD:    seg = SEG_HEX_D;
         4'hE:    seg = SEG_HEX_E;
         default: seg = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed hex seven-segment display driver running on the board clock.
// The displayed word is snapshotted once per frame so digits never tear.
// Optional feature macro: SM_HEX_DISPLAY_LZB_EN enables leading-zero blanking
// (digits above the most significant nonzero nibble are dark; digit 0 always lit).
module sm_hex_display
   import sm_display_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SCAN_SHIFT   = 10,
   parameter int BLANK        = 16,
   parameter int COMMON_ANODE = 1
) (
   input  logic                      clkIn,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [4*MAX_DIGITS-1:0]   data,
   output logic [6:0]                segments,
   output logic [DIGITS-1:0]         anodes,
   output logic                      frameDone
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SCAN_SHIFT-1:0] CNT_MAX   = '1;
   localparam logic [SCAN_SHIFT-1:0] CNT_BLANK = SCAN_SHIFT'(BLANK);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DIGITS - 1);
   // XOR masks that turn active-high internal values into pin polarity.
   localparam logic [DIGITS-1:0]     AN_OFF    = {DIGITS{COMMON_ANODE != 0}};
   localparam logic [6:0]            SEG_OFF   = {7{COMMON_ANODE != 0}};

   logic [SCAN_SHIFT-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*MAX_DIGITS-1:0] snap_q, snap_d;
   logic                    first_q, first_d;
   logic                    frame_done_q, frame_done_d;
   logic [DIGITS-1:0]       anodes_q, anodes_d;
   logic [6:0]              segments_q, segments_d;

   logic                    slot_end;
   logic                    frame_end;
   logic                    snap_load;
   logic [3:0]              nibble;
   logic [6:0]              seg_pat;
   logic [DIGITS-1:0]       onehot;
   logic                    digit_shown;
   logic                    lit;

`ifdef SM_HEX_DISPLAY_LZB_EN
   logic [DIGITS-1:0]       show_q, show_d;

   // A digit is shown when it or any higher digit holds a nonzero nibble;
   // digit 0 is always shown so an all-zero word still reads "0".
   function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*MAX_DIGITS-1:0] w);
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen        = seen | (|w[4*i +: 4]);
         lzb_mask[i] = seen || (i == 0);
      end
   endfunction
`endif

   sm_hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (seg_pat)
   );

   // Scan counters, snapshot capture and frame-boundary detection.
   always_comb begin
      slot_end     = enable && (cnt_q == CNT_MAX);
      frame_end    = slot_end && (idx_q == IDX_LAST);
      snap_load    = frame_end || (enable && first_q);
      cnt_d        = enable ? cnt_q + SCAN_SHIFT'(1) : cnt_q;
      idx_d        = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      first_d      = first_q && !enable;
      snap_d       = snap_load ? data : snap_q;
      frame_done_d = frame_end;
`ifdef SM_HEX_DISPLAY_LZB_EN
      show_d       = snap_load ? lzb_mask(data) : show_q;
`endif
   end

   // Select the current digit's nibble and build the next anode/segment drive.
   always_comb begin
      nibble      = 4'h0;
      onehot      = '0;
      digit_shown = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nibble    = snap_q[4*i +: 4];
            onehot[i] = 1'b1;
`ifdef SM_HEX_DISPLAY_LZB_EN
            digit_shown = show_q[i];
`endif
         end
      end
      lit        = enable && (cnt_q >= CNT_BLANK) && digit_shown;
      anodes_d   = (lit ? onehot  : '0)    ^ AN_OFF;
      segments_d = (lit ? seg_pat : 7'h00) ^ SEG_OFF;
   end

   // State and output registers; outputs idle in their inactive polarity.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         snap_q       <= '0;
         first_q      <= 1'b1;
         frame_done_q <= 1'b0;
         anodes_q     <= AN_OFF;
         segments_q   <= SEG_OFF;
`ifdef SM_HEX_DISPLAY_LZB_EN
         show_q       <= DIGITS'(1);
`endif
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         first_q      <= first_d;
         frame_done_q <= frame_done_d;
         anodes_q     <= anodes_d;
         segments_q   <= segments_d;
`ifdef SM_HEX_DISPLAY_LZB_EN
         show_q       <= show_d;
`endif
      end
   end

   assign anodes    = anodes_q;
   assign segments  = segments_q;
   assign frameDone = frame_done_q;

endmodule
